// File: rtl/mips_pkg.sv
// mips_pkg: shared pipeline constants for the ID/EX control bundle.
package mips_pkg;
  localparam int CTRLW = 12;
  localparam int CTRL_MEMREAD = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_REGWRITE = 2;
  localparam int CTRL_ALUSRC = 3;
  localparam int ALUOP_LO = 4;
  localparam int ALUOP_HI = 7;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef logic [CTRLW-1:0] ctrl_t;
endpackage

// File: rtl/wb_bypass32.sv
// wb_bypass32: substitutes write-back data for a register read that matches it.
module wb_bypass32 #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             wb_en,
  input  logic [RADDR-1:0] wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [RADDR-1:0] sel,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  assign q = (wb_en && wb_addr == sel && sel != '0) ? wb_data : d;
endmodule

// File: rtl/idex_latch.sv
// idex_latch: ID/EX pipeline register with write-back bypass, load-use bubbles, stall and flush.
module idex_latch
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] abus,
  input  logic [WIDTH-1:0] bbus,
  input  logic [WIDTH-1:0] imm,
  input  logic [RADDR-1:0] rs_sel,
  input  logic [RADDR-1:0] rt_sel,
  input  logic [RADDR-1:0] rd_sel,
  input  ctrl_t            ctrl_in,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [RADDR-1:0] wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] imm_out,
  output logic [RADDR-1:0] rd_out,
  output ctrl_t            ctrl_out,
  output logic             valid_out,
  output logic             load_use
);
  logic [RADDR-1:0] rs_q, rt_q;
  logic [WIDTH-1:0] a_ld, b_ld, a_st, b_st;
  wb_bypass32 #(.WIDTH(WIDTH), .RADDR(RADDR)) u_ld_a (.wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .sel(rs_sel), .d(abus), .q(a_ld));
  wb_bypass32 #(.WIDTH(WIDTH), .RADDR(RADDR)) u_ld_b (.wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .sel(rt_sel), .d(bbus), .q(b_ld));
  // held operands keep tracking write-back so a long stall never leaves them stale
  wb_bypass32 #(.WIDTH(WIDTH), .RADDR(RADDR)) u_st_a (.wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .sel(rs_q), .d(a_out), .q(a_st));
  wb_bypass32 #(.WIDTH(WIDTH), .RADDR(RADDR)) u_st_b (.wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .sel(rt_q), .d(b_out), .q(b_st));
  assign load_use = valid_out && ctrl_out[CTRL_MEMREAD] && rd_out != '0 && valid_in &&
                    (rd_out == rs_sel || rd_out == rt_sel);
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush || (!stall && load_use)) begin
      a_out     <= '0;
      b_out     <= '0;
      imm_out   <= '0;
      rd_out    <= '0;
      ctrl_out  <= '0;
      valid_out <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
    end else if (stall) begin
      a_out <= a_st;
      b_out <= b_st;
    end else begin
      a_out     <= a_ld;
      b_out     <= b_ld;
      imm_out   <= imm;
      rd_out    <= rd_sel;
      ctrl_out  <= valid_in ? ctrl_in : '0;
      valid_out <= valid_in;
      rs_q      <= rs_sel;
      rt_q      <= rt_sel;
    end
  end
endmodule

// File: tb/tb_idex_latch.sv
// tb_idex_latch: directed vector table, async-reset sequence and randomized model check.
module tb_idex_latch;
  import mips_pkg::*;
  typedef struct packed {
    logic [31:0] a, b, imm;
    logic [4:0]  rs, rt, rd;
    logic [11:0] ctrl;
    logic        vin, stall, flush, wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
  } in_t;
  typedef struct packed {
    logic [31:0] a, b, imm;
    logic [4:0]  rd;
    logic [11:0] ctrl;
    logic        v, lu;
  } out_t;
  typedef struct packed {
    logic [31:0] a, b, imm;
    logic [4:0]  rd, rsq, rtq;
    logic [11:0] ctrl;
    logic        v;
  } ex_t;
  typedef struct {
    string name;
    in_t   i;
    out_t  e;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] abus, bbus, imm, wb_data, a_out, b_out, imm_out;
  logic [4:0]  rs_sel, rt_sel, rd_sel, wb_addr, rd_out;
  ctrl_t       ctrl_in, ctrl_out;
  logic        valid_in, stall, flush, wb_en, valid_out, load_use;
  int tests = 0, fails = 0;
  vec_t v[16];
  ex_t m;
  in_t cur;

  always #5 clk = ~clk;

  idex_latch dut (.clk(clk), .reset(reset), .abus(abus), .bbus(bbus), .imm(imm),
    .rs_sel(rs_sel), .rt_sel(rt_sel), .rd_sel(rd_sel), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .a_out(a_out), .b_out(b_out), .imm_out(imm_out), .rd_out(rd_out), .ctrl_out(ctrl_out),
    .valid_out(valid_out), .load_use(load_use));

  function automatic in_t mk(logic [31:0] a, logic [31:0] b, logic [31:0] im, logic [4:0] rs,
                             logic [4:0] rt, logic [4:0] rd, logic [11:0] c, logic [3:0] f,
                             logic [4:0] wba, logic [31:0] wbd);
    return '{a, b, im, rs, rt, rd, c, f[3], f[2], f[1], f[0], wba, wbd};
  endfunction

  function automatic out_t ex(logic [31:0] a, logic [31:0] b, logic [31:0] im, logic [4:0] rd,
                              logic [11:0] c, logic vv, logic lu);
    return '{a, b, im, rd, c, vv, lu};
  endfunction

  task automatic drive(in_t i);
    abus = i.a; bbus = i.b; imm = i.imm; rs_sel = i.rs; rt_sel = i.rt; rd_sel = i.rd;
    ctrl_in = i.ctrl; valid_in = i.vin; stall = i.stall; flush = i.flush;
    wb_en = i.wbe; wb_addr = i.wba; wb_data = i.wbd;
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chk_out(string n, out_t e);
    chk({n, "_a"}, a_out, e.a);
    chk({n, "_b"}, b_out, e.b);
    chk({n, "_imm"}, imm_out, e.imm);
    chk({n, "_rd"}, 32'(rd_out), 32'(e.rd));
    chk({n, "_ctrl"}, 32'(ctrl_out), 32'(e.ctrl));
    chk({n, "_valid"}, 32'(valid_out), 32'(e.v));
  endtask

  // reference: freshest value of register r given the register-file read value
  function automatic logic [31:0] fresh(in_t i, logic [4:0] r, logic [31:0] rf);
    return (i.wbe && i.wba == r && r != REG_ZERO) ? i.wbd : rf;
  endfunction

  function automatic logic mlu(ex_t s, in_t i);
    return s.v && s.ctrl[CTRL_MEMREAD] && s.rd != 0 && i.vin && (s.rd == i.rs || s.rd == i.rt);
  endfunction

  function automatic ex_t nxt(ex_t s, in_t i);
    ex_t r = s;
    if (i.flush || (!i.stall && mlu(s, i))) r = '0;
    else if (i.stall) begin
      r.a = fresh(i, s.rsq, s.a);
      r.b = fresh(i, s.rtq, s.b);
    end else
      r = '{fresh(i, i.rs, i.a), fresh(i, i.rt, i.b), i.imm, i.rd, i.rs, i.rt,
            i.vin ? i.ctrl : 12'h0, i.vin};
    return r;
  endfunction

  initial begin
    v[0]  = '{"load",    mk(32'h11, 32'h22, 32'hFFFFFFF0, 5'd1, 5'd2, 5'd7, 12'h00C, 4'b1000, 5'd0, 32'h0),
                         ex(32'h11, 32'h22, 32'hFFFFFFF0, 5'd7, 12'h00C, 1'b1, 1'b0)};
    v[1]  = '{"byp_a",   mk(32'hAAAA, 32'hBBBB, 32'h4, 5'd5, 5'd6, 5'd8, 12'h004, 4'b1001, 5'd5, 32'h1234),
                         ex(32'h1234, 32'hBBBB, 32'h4, 5'd8, 12'h004, 1'b1, 1'b0)};
    v[2]  = '{"byp_r0",  mk(32'hAAAA, 32'hBBBB, 32'h4, 5'd0, 5'd6, 5'd9, 12'h004, 4'b1001, 5'd0, 32'h1234),
                         ex(32'hAAAA, 32'hBBBB, 32'h4, 5'd9, 12'h004, 1'b1, 1'b0)};
    v[3]  = '{"ld_rs3",  mk(32'h3333, 32'h4444, 32'h0, 5'd3, 5'd4, 5'd10, 12'h001, 4'b1000, 5'd0, 32'h0),
                         ex(32'h3333, 32'h4444, 32'h0, 5'd10, 12'h001, 1'b1, 1'b0)};
    v[4]  = '{"stall1",  mk(32'h0, 32'h0, 32'h0, 5'd12, 5'd13, 5'd5, 12'h000, 4'b1100, 5'd0, 32'h0),
                         ex(32'h3333, 32'h4444, 32'h0, 5'd10, 12'h001, 1'b1, 1'b0)};
    v[5]  = '{"stall2",  mk(32'h0, 32'h0, 32'h0, 5'd12, 5'd13, 5'd5, 12'h000, 4'b1101, 5'd3, 32'hBEEF),
                         ex(32'hBEEF, 32'h4444, 32'h0, 5'd10, 12'h001, 1'b1, 1'b0)};
    v[6]  = '{"stall3",  mk(32'h0, 32'h0, 32'h0, 5'd12, 5'd13, 5'd5, 12'h000, 4'b1100, 5'd0, 32'h0),
                         ex(32'hBEEF, 32'h4444, 32'h0, 5'd10, 12'h001, 1'b1, 1'b0)};
    v[7]  = '{"lu_bub",  mk(32'h5, 32'h6, 32'h7, 5'd1, 5'd10, 5'd11, 12'h004, 4'b1000, 5'd0, 32'h0),
                         ex(32'h0, 32'h0, 32'h0, 5'd0, 12'h000, 1'b0, 1'b1)};
    v[8]  = '{"lu_next", mk(32'h5, 32'h6, 32'h7, 5'd1, 5'd10, 5'd11, 12'h004, 4'b1000, 5'd0, 32'h0),
                         ex(32'h5, 32'h6, 32'h7, 5'd11, 12'h004, 1'b1, 1'b0)};
    v[9]  = '{"inval",   mk(32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd12, 12'hFFF, 4'b0000, 5'd0, 32'h0),
                         ex(32'h1, 32'h2, 32'h3, 5'd12, 12'h000, 1'b0, 1'b0)};
    v[10] = '{"ld_mr",   mk(32'h9, 32'h8, 32'h0, 5'd14, 5'd15, 5'd13, 12'h001, 4'b1000, 5'd0, 32'h0),
                         ex(32'h9, 32'h8, 32'h0, 5'd13, 12'h001, 1'b1, 1'b0)};
    v[11] = '{"stl_fl",  mk(32'h0, 32'h0, 32'h0, 5'd13, 5'd1, 5'd2, 12'h004, 4'b1110, 5'd0, 32'h0),
                         ex(32'h0, 32'h0, 32'h0, 5'd0, 12'h000, 1'b0, 1'b1)};
    v[12] = '{"ld_rd0",  mk(32'h1, 32'h1, 32'h0, 5'd0, 5'd0, 5'd0, 12'h001, 4'b1000, 5'd0, 32'h0),
                         ex(32'h1, 32'h1, 32'h0, 5'd0, 12'h001, 1'b1, 1'b0)};
    v[13] = '{"no_lu0",  mk(32'h2, 32'h2, 32'h0, 5'd0, 5'd0, 5'd5, 12'h000, 4'b1000, 5'd0, 32'h0),
                         ex(32'h2, 32'h2, 32'h0, 5'd5, 12'h000, 1'b1, 1'b0)};
    v[14] = '{"stl_q0",  mk(32'h0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd3, 12'h000, 4'b1101, 5'd0, 32'hDEAD),
                         ex(32'h2, 32'h2, 32'h0, 5'd5, 12'h000, 1'b1, 1'b0)};
    v[15] = '{"flush",   mk(32'h7, 32'h7, 32'h7, 5'd1, 5'd1, 5'd1, 12'h00F, 4'b1010, 5'd0, 32'h0),
                         ex(32'h0, 32'h0, 32'h0, 5'd0, 12'h000, 1'b0, 1'b0)};
    drive('0);
    repeat (2) @(posedge clk);
    #1;
    chk_out("rst", ex(32'h0, 32'h0, 32'h0, 5'd0, 12'h0, 1'b0, 1'b0));
    chk("rst_lu", 32'(load_use), 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      drive(v[k].i);
      #1;
      chk({v[k].name, "_lu"}, 32'(load_use), 32'(v[k].e.lu));
      @(posedge clk);
      #1;
      chk_out(v[k].name, v[k].e);
    end
    // async reset between edges with a pending load-use
    drive(mk(32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd4, 12'h001, 4'b1000, 5'd0, 32'h0));
    @(posedge clk);
    #1;
    drive(mk(32'h5, 32'h6, 32'h7, 5'd1, 5'd4, 5'd9, 12'h004, 4'b1000, 5'd0, 32'h0));
    #1;
    chk("arst_pre_lu", 32'(load_use), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk_out("arst", ex(32'h0, 32'h0, 32'h0, 5'd0, 12'h0, 1'b0, 1'b0));
    chk("arst_lu", 32'(load_use), 32'h0);
    @(posedge clk);
    #1;
    chk_out("arst_hold", ex(32'h0, 32'h0, 32'h0, 5'd0, 12'h0, 1'b0, 1'b0));
    #2 reset = 1'b0;
    #1;
    chk_out("arst_rel", ex(32'h0, 32'h0, 32'h0, 5'd0, 12'h0, 1'b0, 1'b0));
    m = '0;
    for (int n = 0; n < 400; n++) begin
      cur = '{$urandom, $urandom, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 12'($urandom), ($urandom % 4) != 0, ($urandom % 5) == 0,
              ($urandom % 9) == 0, 1'($urandom), 5'($urandom_range(0, 3)), $urandom};
      drive(cur);
      #1;
      chk("rnd_lu", 32'(load_use), 32'(mlu(m, cur)));
      m = nxt(m, cur);
      @(posedge clk);
      #1;
      chk_out("rnd", '{m.a, m.b, m.imm, m.rd, m.ctrl, m.v, 1'b0});
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
